// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   MEM-stage access controller for the pipelined MIPS core. Sits between the
//   EX/MEM register and a slow, handshaked, single-port word memory.
//   - Stores are posted through a one-entry write buffer. The buffer is the
//     registered bus write itself, so it is valid exactly while in WBUF.
//   - Loads stall the pipeline until data returns. A load that hits the
//     buffered store is forwarded combinationally.
//   - A bus access left unacknowledged for TIMEOUT request cycles is
//     abandoned, and BusErr pulses for one cycle.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-low reset
//   MemRead, MemWrite    load / store in MEM (both high = store only)
//   address, WriteData   byte address and store data from EX/MEM
//   ReadData             load data for MEM/WB (forwarded on a buffer hit)
//   MemStall             combinational global pipeline hold
//   AddrErr              combinational, misaligned access dropped this cycle
//   BusErr               registered one-cycle pulse after a bus timeout
//   mem_req/we/addr/wdata  registered bus request, held until done
//   mem_ack, mem_rdata   single-cycle completion pulse and read data
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemStall,
  output logic              AddrErr,
  output logic              BusErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WA_W  = ADDR_W - 2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WBUF, S_LOAD, S_DONE} state_e;

  state_e            state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              req_q,     req_d;
  logic              we_q,      we_d;
  logic [WA_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              bus_err_q, bus_err_d;

  logic            aligned;
  logic            wr_acc;
  logic            rd_acc;
  logic            hit;
  logic            timeout_hit;
  logic            done;
  logic [WA_W-1:0] word_addr;

  assign word_addr = address[ADDR_W-1:2];
  assign aligned   = (address[1:0] == 2'b00);
  // A simultaneous read and write is handled as the write alone.
  assign wr_acc    = MemWrite & aligned;
  assign rd_acc    = MemRead & ~MemWrite & aligned;
  assign hit       = (state_q == S_WBUF) && rd_acc && (addr_q == word_addr);
  // Timeout fires in the request cycle that takes the counter to TIMEOUT;
  // an ack in that same cycle still wins.
  assign timeout_hit = req_q && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign done        = mem_ack || timeout_hit;

  // State register (also holds the bus, buffer, read-data and error flops).
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    bus_err_d = timeout_hit;

    if (req_q && !mem_ack) cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (wr_acc) begin
          state_d = S_WBUF;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = word_addr;
          wdata_d = WriteData;
          cnt_d   = '0;
        end else if (rd_acc) begin
          state_d = S_LOAD;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = word_addr;
          cnt_d   = '0;
        end
      end
      S_WBUF: begin
        if (done) begin
          // A pending store is only taken when it was not stalled (real ack);
          // after a timeout it is re-presented and taken from IDLE.
          if (wr_acc && mem_ack) begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = word_addr;
            wdata_d = WriteData;
            cnt_d   = '0;
          end else if (rd_acc && !hit) begin
            state_d = S_LOAD;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = word_addr;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
          end
        end
      end
      S_LOAD: begin
        if (done) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          rdata_d = mem_ack ? mem_rdata : '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    ReadData = hit ? wdata_q : rdata_q;
    AddrErr  = (MemRead | MemWrite) & ~aligned;
    MemStall = 1'b0;
    case (state_q)
      S_IDLE:  MemStall = rd_acc;
      S_WBUF:  MemStall = (wr_acc & ~mem_ack) | (rd_acc & ~hit);
      S_LOAD:  MemStall = 1'b1;
      default: MemStall = 1'b0;
    endcase
    // The hold must drop as soon as reset is asserted, even with a load still
    // presented by the pipeline.
    MemStall = MemStall & rst;
  end

  assign BusErr    = bus_err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Directed scenarios for the controller followed by a randomized run of
//   loads/stores. The bench acts as the pipeline (holds an instruction while
//   MemStall is high) and as the memory (random or fixed ack latency).
//   Expected load data comes from an architectural memory array updated in
//   program order.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  localparam int LIM = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [31:0] address, WriteData, ReadData;
  logic        MemStall, AddrErr, BusErr;
  logic        mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        slv_ack, man_ack;
  logic [31:0] slv_rdata;
  assign mem_ack   = slv_ack | man_ack;
  assign mem_rdata = slv_rdata;

  data_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .WriteData(WriteData), .ReadData(ReadData),
    .MemStall(MemStall), .AddrErr(AddrErr), .BusErr(BusErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model (slave) ----------------
  logic [31:0] smem [logic [29:0]];
  bit rand_delay = 0;
  bit never_ack  = 0;
  int fixed_target = 0;
  int age = 0;
  int target = 0;

  initial begin
    slv_ack   = 1'b0;
    slv_rdata = '0;
  end

  always @(posedge clk) begin
    #1;
    slv_ack   = 1'b0;
    slv_rdata = $urandom;
    if (mem_req === 1'b1) begin
      if (age == 0) target = rand_delay ? int'($urandom_range(0, 2)) : fixed_target;
      if (!never_ack && age == target) begin
        slv_ack = 1'b1;
        if (mem_we) smem[mem_addr] = mem_wdata;
        else        slv_rdata = smem.exists(mem_addr) ? smem[mem_addr] : '0;
        age = 0;
      end else begin
        age++;
      end
    end else begin
      age = 0;
    end
  end

  // ---------------- bus monitor ----------------
  int cyc = 0;
  int req_rd_cycles = 0, req_wr_cycles = 0, n_rd_ack = 0, n_wr_ack = 0;
  int bus_err_cycles = 0, rd_start_cyc = -1, wr_ack_cyc = -1;
  bit prev_rd = 0;

  always @(negedge clk) begin
    cyc++;
    if (mem_req === 1'b1) begin
      if (mem_we) req_wr_cycles++;
      else begin
        req_rd_cycles++;
        if (!prev_rd) rd_start_cyc = cyc;
      end
      if (mem_ack === 1'b1) begin
        if (mem_we) begin n_wr_ack++; wr_ack_cyc = cyc; end
        else n_rd_ack++;
      end
    end
    prev_rd = (mem_req === 1'b1) && (mem_we === 1'b0);
    if (BusErr === 1'b1) bus_err_cycles++;
  end

  task automatic clear_counts();
    req_rd_cycles = 0; req_wr_cycles = 0; n_rd_ack = 0; n_wr_ack = 0;
    bus_err_cycles = 0; rd_start_cyc = -1; wr_ack_cyc = -1;
  endtask

  // ---------------- pipeline-side helpers ----------------
  // Called just after a rising edge. Presents one MEM-stage op and holds it
  // while MemStall is high; returns just after the edge that advances it.
  task automatic run_op(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, output int stalls,
                        output logic [31:0] rdat, output logic aerr);
    MemRead = rd; MemWrite = wr; address = a; WriteData = d;
    stalls = 0;
    @(negedge clk);
    aerr = AddrErr;
    while (MemStall === 1'b1 && stalls < LIM) begin
      stalls++;
      @(negedge clk);
    end
    rdat = ReadData;
    check("stall_bound", 64'(stalls < LIM), 64'd1);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] ref_mem [8];

  initial begin
    int st;
    logic [31:0] rd_v;
    logic ae;
    int kind, idx;
    logic [31:0] a, d;

    rst = 1'b1; man_ack = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; address = '0; WriteData = '0;

    // ---- reset values, no clock edge needed ----
    #2 rst = 1'b0;
    #1;
    check("rst_mem_req",   64'(mem_req),   64'd0);
    check("rst_mem_we",    64'(mem_we),    64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_readdata",  64'(ReadData),  64'd0);
    check("rst_buserr",    64'(BusErr),    64'd0);
    check("rst_stall",     64'(MemStall),  64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // ---- posted store: sw 0xCAFEF00D -> 0x40, ack on 3rd request cycle ----
    fixed_target = 2; clear_counts();
    run_op(0, 1, 32'h40, 32'hCAFEF00D, st, rd_v, ae);
    check("store_stall", 64'(st), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("store_nostall", 64'(MemStall), 64'd0);
      if (mem_req === 1'b1) begin
        check("store_addr", 64'(mem_addr), 64'h10);
        check("store_we",   64'(mem_we),   64'd1);
      end
      @(posedge clk); #1;
    end
    check("store_req_cycles", 64'(req_wr_cycles), 64'd3);
    check("store_acks",       64'(n_wr_ack),      64'd1);
    check("store_mem",        64'(smem[30'h10]),  64'hCAFEF00D);

    // ---- load miss: lw 0x80, ack on 4th request cycle ----
    smem[30'h20] = 32'h12345678;
    fixed_target = 3; clear_counts();
    run_op(1, 0, 32'h80, 32'h0, st, rd_v, ae);
    check("load_stall", 64'(st),   64'd5);
    check("load_data",  64'(rd_v), 64'h12345678);
    idle(3);
    check("load_reads",      64'(n_rd_ack),      64'd1);
    check("load_req_cycles", 64'(req_rd_cycles), 64'd4);

    // ---- store -> load forward from the write buffer ----
    clear_counts();
    run_op(0, 1, 32'h20, 32'hA5A5A5A5, st, rd_v, ae);
    check("fwd_store_stall", 64'(st), 64'd0);
    run_op(1, 0, 32'h20, 32'h0, st, rd_v, ae);
    check("fwd_stall", 64'(st),   64'd0);
    check("fwd_data",  64'(rd_v), 64'hA5A5A5A5);
    idle(6);
    check("fwd_no_read", 64'(req_rd_cycles), 64'd0);
    check("fwd_mem",     64'(smem[30'h8]),   64'hA5A5A5A5);

    // ---- store then load of another word: load waits for the write ----
    smem[30'h9] = 32'h24242424;
    clear_counts();
    run_op(0, 1, 32'h20, 32'h3C3C3C3C, st, rd_v, ae);
    run_op(1, 0, 32'h24, 32'h0, st, rd_v, ae);
    check("miss_stall", 64'(st),   64'd8);
    check("miss_data",  64'(rd_v), 64'h24242424);
    idle(3);
    check("miss_rd_after_wack", 64'(rd_start_cyc), 64'(wr_ack_cyc + 1));
    check("miss_mem",           64'(smem[30'h8]),  64'h3C3C3C3C);

    // ---- timeout: read never acknowledged ----
    never_ack = 1; clear_counts();
    run_op(1, 0, 32'h100, 32'h0, st, rd_v, ae);
    check("to_stall", 64'(st),   64'd5);
    check("to_data",  64'(rd_v), 64'd0);
    idle(4);
    check("to_req_cycles", 64'(req_rd_cycles),  64'd4);
    check("to_buserr",     64'(bus_err_cycles), 64'd1);
    check("to_req_low",    64'(mem_req),        64'd0);
    never_ack = 0;

    // ---- misaligned store, then read+write together ----
    fixed_target = 0; clear_counts();
    run_op(0, 1, 32'h42, 32'hDEADBEEF, st, rd_v, ae);
    check("mis_addrerr", 64'(ae), 64'd1);
    check("mis_stall",   64'(st), 64'd0);
    idle(3);
    check("mis_no_req", 64'(req_wr_cycles + req_rd_cycles), 64'd0);
    run_op(1, 1, 32'h60, 32'h11112222, st, rd_v, ae);
    check("dual_stall", 64'(st), 64'd0);
    idle(3);
    check("dual_writes", 64'(n_wr_ack),      64'd1);
    check("dual_reads",  64'(req_rd_cycles), 64'd0);
    check("dual_mem",    64'(smem[30'h18]),  64'h11112222);

    // ---- async reset while a load is on the bus ----
    never_ack = 1;
    MemRead = 1'b1; address = 32'h80;
    @(negedge clk); @(negedge clk);
    check("ar_req_before", 64'(mem_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_req",   64'(mem_req),  64'd0);
    check("ar_stall", 64'(MemStall), 64'd0);
    @(negedge clk);
    MemRead = 1'b0;
    rst = 1'b1;
    never_ack = 0;
    @(posedge clk); #1 man_ack = 1'b1;
    @(negedge clk);
    check("late_ack_req",   64'(mem_req),  64'd0);
    check("late_ack_stall", 64'(MemStall), 64'd0);
    @(posedge clk); #1 man_ack = 1'b0;
    @(negedge clk);
    check("late_ack_rdata", 64'(ReadData), 64'd0);
    check("late_ack_req2",  64'(mem_req),  64'd0);
    check("late_ack_err",   64'(BusErr),   64'd0);
    @(posedge clk); #1;

    // ---- randomized program against the architectural memory ----
    rand_delay = 1;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      smem[30'h80 + 30'(i)] = ref_mem[i];
    end
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, 7);
      a    = 32'h200 + 32'(idx * 4);
      d    = $urandom;
      if (kind < 4) begin
        run_op(0, 1, a, d, st, rd_v, ae);
        ref_mem[idx] = d;
      end else if (kind < 8) begin
        run_op(1, 0, a, d, st, rd_v, ae);
        check("rnd_load", 64'(rd_v), 64'(ref_mem[idx]));
      end else if (kind == 8) begin
        run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) | 1'b0,
               a + 32'($urandom_range(1, 3)), d, st, rd_v, ae);
        if (st == 0 && ae !== 1'b1 && (MemRead | MemWrite)) check("rnd_mis", 64'(ae), 64'd1);
      end else begin
        run_op(1, 1, a, d, st, rd_v, ae);
        ref_mem[idx] = d;
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(8);
    for (int i = 0; i < 8; i++)
      check("rnd_final_mem", 64'(smem[30'h80 + 30'(i)]), 64'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
